// File: rtl/mem_responder_pkg.sv
// Shared types and default memory depths for the boot-loading memory responder.
package mem_responder_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_IMEM_WORDS = 256;
    localparam int DEFAULT_DMEM_WORDS = 256;

endpackage

// File: rtl/mem_responder_boot_loader.sv
// Packs a little-endian boot byte stream into 32-bit instruction words.
// On the accepting edge it emits a write strobe and the word pointer moves on.
module boot_loader
    import mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter int IW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accept,
    input  logic [7:0]    boot_byte,
    input  logic          boot_last,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic [31:0]   wr_data,
    output logic          boot_done,
    output logic          boot_ovf
);

    localparam logic [IW-1:0] PTR_MAX = IW'(IMEM_WORDS - 1);

    logic [1:0]    byte_cnt;
    logic [23:0]   asm_q;
    logic [IW-1:0] word_ptr;

    // Bytes already held sit in their final lanes, so a short last word
    // is zero-filled simply by leaving the upper lanes empty.
    always_comb begin
        wr_data = 32'h0;
        case (byte_cnt)
            2'd0: wr_data = {24'h0, boot_byte};
            2'd1: wr_data = {16'h0, boot_byte, asm_q[7:0]};
            2'd2: wr_data = {8'h0, boot_byte, asm_q[15:0]};
            2'd3: wr_data = {boot_byte, asm_q[23:0]};
            default: wr_data = 32'h0;
        endcase
    end

    assign wr_en  = accept && ((byte_cnt == 2'd3) || boot_last);
    assign wr_idx = word_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt  <= 2'd0;
            asm_q     <= 24'h0;
            word_ptr  <= '0;
            boot_done <= 1'b0;
            boot_ovf  <= 1'b0;
        end else if (accept) begin
            if (wr_en) begin
                byte_cnt <= 2'd0;
                asm_q    <= 24'h0;
                word_ptr <= word_ptr + 1'b1;
                if (word_ptr == PTR_MAX) begin
                    boot_ovf <= 1'b1;
                end
                if (boot_last) begin
                    boot_done <= 1'b1;
                end
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: asm_q[7:0]   <= boot_byte;
                    2'd1: asm_q[15:8]  <= boot_byte;
                    2'd2: asm_q[23:16] <= boot_byte;
                    default: asm_q     <= asm_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Instruction/data memory responder: boots imem from a byte stream, then
// serves combinational fetches, loads and edge-timed stores to the core.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter int DMEM_WORDS = DEFAULT_DMEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_address,
    output logic [31:0] Ins_in_PC,
    input  logic        load_MEM,
    input  logic        store_MEM,
    input  logic [31:0] mem_address_MEM,
    input  logic [31:0] mem_data_MEM,
    output logic [31:0] mem_data_recive,
    input  logic        boot_valid,
    input  logic [7:0]  boot_byte,
    input  logic        boot_last,
    output logic        boot_ready,
    output logic        core_run,
    output logic        misalign_err,
    output logic        boot_ovf,
    output state_e      state_dbg
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    state_e        state;
    logic          boot_done;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic          accept;
    logic          aligned;
    logic [DW-1:0] d_idx;
    logic          unused_addr_bits;

    // Boot handshake: a byte moves on any rising edge where boot_valid and
    // boot_ready are both 1; boot_ready drops once the last byte is taken.
    assign boot_ready = (state == BOOT) && !boot_done;
    assign accept     = boot_valid && boot_ready;
    assign state_dbg  = state;

    boot_loader #(
        .IMEM_WORDS(IMEM_WORDS),
        .IW        (IW)
    ) u_boot_loader (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .boot_byte (boot_byte),
        .boot_last (boot_last),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .boot_done (boot_done),
        .boot_ovf  (boot_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            core_run <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_done) begin
                        state    <= RUN;
                        core_run <= 1'b1;
                    end
                end
                RUN: begin
                    state    <= RUN;
                    core_run <= 1'b1;
                end
                default: begin
                    state    <= BOOT;
                    core_run <= 1'b0;
                end
            endcase
        end
    end

    assign aligned = (mem_address_MEM[1:0] == 2'b00);
    assign d_idx   = mem_address_MEM[DW+1:2];

    assign Ins_in_PC       = core_run ? imem[PC_address[IW+1:2]] : 32'h0;
    assign mem_data_recive = (core_run && load_MEM && aligned) ? dmem[d_idx] : 32'h0;

    // Memory arrays deliberately have no reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            imem[wr_idx] <= wr_data;
        end
        if (core_run && store_MEM && aligned) begin
            dmem[d_idx] <= mem_data_MEM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else if (core_run && (load_MEM || store_MEM) && !aligned) begin
            misalign_err <= 1'b1;
        end
    end

    assign unused_addr_bits = ^{PC_address[31:IW+2], PC_address[1:0],
                                mem_address_MEM[31:DW+2]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: boot, fetch, load/store, misalignment,
// overflow and reset-mid-boot behaviour with hand-computed expectations.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int IMEM_WORDS = 16;
    localparam int DMEM_WORDS = 16;

    logic        clk;
    logic        reset;
    logic [31:0] PC_address;
    logic [31:0] Ins_in_PC;
    logic        load_MEM;
    logic        store_MEM;
    logic [31:0] mem_address_MEM;
    logic [31:0] mem_data_MEM;
    logic [31:0] mem_data_recive;
    logic        boot_valid;
    logic [7:0]  boot_byte;
    logic        boot_last;
    logic        boot_ready;
    logic        core_run;
    logic        misalign_err;
    logic        boot_ovf;
    state_e      state_dbg;

    int tests_run;
    int tests_failed;

    mem_responder #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .PC_address      (PC_address),
        .Ins_in_PC       (Ins_in_PC),
        .load_MEM        (load_MEM),
        .store_MEM       (store_MEM),
        .mem_address_MEM (mem_address_MEM),
        .mem_data_MEM    (mem_data_MEM),
        .mem_data_recive (mem_data_recive),
        .boot_valid      (boot_valid),
        .boot_byte       (boot_byte),
        .boot_last       (boot_last),
        .boot_ready      (boot_ready),
        .core_run        (core_run),
        .misalign_err    (misalign_err),
        .boot_ovf        (boot_ovf),
        .state_dbg       (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        boot_valid = 1'b1;
        boot_byte  = b;
        boot_last  = last;
        step();
        boot_valid = 1'b0;
        boot_last  = 1'b0;
        boot_byte  = 8'h00;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset           = 1'b1;
        PC_address      = 32'h0;
        load_MEM        = 1'b0;
        store_MEM       = 1'b0;
        mem_address_MEM = 32'h0;
        mem_data_MEM    = 32'h0;
        boot_valid      = 1'b0;
        boot_byte       = 8'h00;
        boot_last       = 1'b0;
        #2;

        // Reset state, observed asynchronously while reset is held.
        reset = 1'b0;
        #1;
        check("rst_core_run", {31'b0, core_run}, 32'h0);
        check("rst_boot_ready", {31'b0, boot_ready}, 32'h1);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
        check("rst_ovf", {31'b0, boot_ovf}, 32'h0);
        check("rst_ins_nop", Ins_in_PC, 32'h0);
        step();
        reset = 1'b1;
        #1;

        // Data accesses during BOOT are ignored and raise nothing.
        load_MEM = 1'b1; store_MEM = 1'b1; mem_address_MEM = 32'h13;
        #1;
        check("boot_load_zero", mem_data_recive, 32'h0);
        step();
        check("boot_no_misalign", {31'b0, misalign_err}, 32'h0);
        load_MEM = 1'b0; store_MEM = 1'b0; mem_address_MEM = 32'h0;

        // Boot image: one full word, then a short zero-filled word.
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b1);
        check("run_not_yet", {31'b0, core_run}, 32'h0);
        check("ready_drop_after_last", {31'b0, boot_ready}, 32'h0);
        step();
        check("core_run_up", {31'b0, core_run}, 32'h1);
        check("ready_low_run", {31'b0, boot_ready}, 32'h0);

        PC_address = 32'h0; #1;
        check("imem0", Ins_in_PC, 32'h12345678);
        PC_address = 32'h4; #1;
        check("imem1_zero_fill", Ins_in_PC, 32'h0000BEEF);
        PC_address = 32'h44; #1;
        check("imem_wrap", Ins_in_PC, 32'h0000BEEF);

        // Store then load on the following cycle, plus modulo wrap of address.
        store_MEM = 1'b1; mem_address_MEM = 32'h10; mem_data_MEM = 32'hCAFEF00D;
        step();
        store_MEM = 1'b0; load_MEM = 1'b1;
        #1;
        check("load_after_store", mem_data_recive, 32'hCAFEF00D);
        mem_address_MEM = 32'h50; #1;
        check("load_wrap", mem_data_recive, 32'hCAFEF00D);
        load_MEM = 1'b0;

        // Simultaneous load+store: pre-write data now, new data after the edge.
        store_MEM = 1'b1; mem_address_MEM = 32'h20; mem_data_MEM = 32'h11111111;
        step();
        load_MEM = 1'b1; mem_data_MEM = 32'h22222222;
        #1;
        check("ld_st_old", mem_data_recive, 32'h11111111);
        step();
        store_MEM = 1'b0;
        #1;
        check("ld_st_new", mem_data_recive, 32'h22222222);
        load_MEM = 1'b0;

        // Misaligned store is suppressed and sets a sticky flag.
        store_MEM = 1'b1; mem_address_MEM = 32'h13; mem_data_MEM = 32'hDEADBEEF;
        #1;
        check("misalign_before_edge", {31'b0, misalign_err}, 32'h0);
        step();
        store_MEM = 1'b0;
        check("misalign_set", {31'b0, misalign_err}, 32'h1);
        load_MEM = 1'b1; mem_address_MEM = 32'h10; #1;
        check("dmem4_unchanged", mem_data_recive, 32'hCAFEF00D);
        mem_address_MEM = 32'h12; #1;
        check("misaligned_load_zero", mem_data_recive, 32'h0);
        load_MEM = 1'b0; mem_address_MEM = 32'h0;
        step(); step(); step();
        check("misalign_sticky", {31'b0, misalign_err}, 32'h1);

        // Reset mid-boot discards the partial word; memories survive.
        reset = 1'b0;
        #1;
        check("rst2_misalign", {31'b0, misalign_err}, 32'h0);
        check("rst2_core_run", {31'b0, core_run}, 32'h0);
        step();
        reset = 1'b1;
        #1;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA6, 1'b0);
        apply_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        step();
        check("reboot_run", {31'b0, core_run}, 32'h1);
        PC_address = 32'h0; #1;
        check("reboot_imem0", Ins_in_PC, 32'h04030201);
        PC_address = 32'h4; #1;
        check("imem1_kept", Ins_in_PC, 32'h0000BEEF);
        load_MEM = 1'b1; mem_address_MEM = 32'h10; #1;
        check("dmem_kept", mem_data_recive, 32'hCAFEF00D);
        load_MEM = 1'b0;

        // Overflow: 4*IMEM_WORDS+4 bytes, byte value equals its stream index.
        apply_reset();
        for (int i = 0; i < 4 * IMEM_WORDS + 4; i++) begin
            send_byte(8'(i), (i == 4 * IMEM_WORDS + 3));
            if (i == 4 * IMEM_WORDS - 5) begin
                check("ovf_not_early", {31'b0, boot_ovf}, 32'h0);
            end
            if (i == 4 * IMEM_WORDS - 1) begin
                check("ovf_at_wrap", {31'b0, boot_ovf}, 32'h1);
            end
        end
        step();
        check("ovf_run", {31'b0, core_run}, 32'h1);
        check("ovf_sticky", {31'b0, boot_ovf}, 32'h1);
        PC_address = 32'h0; #1;
        check("ovf_imem0_last", Ins_in_PC, 32'h43424140);
        PC_address = 32'h4; #1;
        check("ovf_imem1", Ins_in_PC, 32'h07060504);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
